// File: rtl/mbldcm_ramp_sequencer.sv
// Soft-start ramp sequencer: Avalon-MM master that programs the BLDC core,
// steps the frequency target toward a final value and handles abort/fault shutdown.
module mbldcm_ramp_sequencer #(
  parameter int pPollLimit  = 1024,
  parameter int pDwellWidth = 16
) (
  input  logic                   iClock,
  input  logic                   iReset,
  input  logic                   iStart,
  input  logic                   iAbort,
  input  logic [31:0]            iFreqInit,
  input  logic [31:0]            iFreqFinal,
  input  logic [31:0]            iFreqStep,
  input  logic [pDwellWidth-1:0] iDwell,
  output logic                   oBusy,
  output logic                   oDone,
  output logic                   oError,
  output logic [1:0]             oAddr,
  output logic                   oRead,
  input  logic [31:0]            iRdata,
  output logic                   oWrite,
  output logic [31:0]            oWdata,
  input  logic [1:0]             iResp,
  output logic [2:0]             oState
);

  // Bus handshake: no waitrequest, so an access completes in the single cycle its
  // strobe (oRead xor oWrite) is high; iRdata and iResp are valid in that same cycle,
  // and oAddr/oWdata are driven to 0 whenever no strobe is active.

  typedef enum logic [2:0] {
    sIdle, sWrFreq, sWrEn, sPoll, sDwell, sDone, sFault, sAbort
  } tState;

  localparam int cPollW = $clog2(pPollLimit + 1);
  localparam logic [cPollW-1:0] cPollLast = cPollW'(pPollLimit - 1);

  tState                  rState, nextState;
  logic [31:0]            rCur, rFinal, rStep;
  logic [pDwellWidth-1:0] rDwell, rDwellCnt;
  logic [cPollW-1:0]      rPollCnt;
  logic                   rFirst, rError;

  logic [32:0] sumUp, diffDn;
  logic [31:0] nextFreq;
  logic        respErr;
  logic        unusedRdata;

  assign unusedRdata = ^{iRdata[31:2], iRdata[0]};
  assign respErr     = (iResp != 2'b00);

  // Next target in 33-bit arithmetic so up-steps cannot wrap and down-steps clamp at final.
  always_comb begin
    sumUp  = {1'b0, rCur} + {1'b0, rStep};
    diffDn = {1'b0, rCur} - {1'b0, rFinal};
    if (rStep == 32'd0 || rCur == rFinal)
      nextFreq = rFinal;
    else if (rCur < rFinal)
      nextFreq = (sumUp >= {1'b0, rFinal}) ? rFinal : sumUp[31:0];
    else
      nextFreq = (diffDn <= {1'b0, rStep}) ? rFinal : (rCur - rStep);
  end

  always_comb begin
    nextState = rState;
    oWrite    = 1'b0;
    oRead     = 1'b0;
    oAddr     = 2'd0;
    oWdata    = 32'd0;
    case (rState)
      sIdle: if (iStart) nextState = sWrFreq;
      sWrFreq: begin
        oWrite = 1'b1;
        oWdata = rCur;
        if (respErr)     nextState = sFault;
        else if (iAbort) nextState = sAbort;
        else             nextState = rFirst ? sWrEn : sPoll;
      end
      sWrEn: begin
        oWrite = 1'b1;
        oAddr  = 2'd2;
        oWdata = 32'h1;
        if (respErr)     nextState = sFault;
        else if (iAbort) nextState = sAbort;
        else             nextState = sPoll;
      end
      sPoll: begin
        oRead = 1'b1;
        oAddr = 2'd3;
        if (respErr)                   nextState = sFault;
        else if (iAbort)               nextState = sAbort;
        else if (iRdata[1])            nextState = sDwell;
        else if (rPollCnt == cPollLast) nextState = sFault;
      end
      sDwell: begin
        if (iAbort) nextState = sAbort;
        else if (rDwellCnt == '0) nextState = (rCur == rFinal) ? sDone : sWrFreq;
      end
      sDone: nextState = iAbort ? sAbort : sIdle;
      sFault, sAbort: begin
        oWrite    = 1'b1;
        oAddr     = 2'd2;
        nextState = sIdle;
      end
      default: nextState = sIdle;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      rState    <= sIdle;
      rCur      <= 32'd0;
      rFinal    <= 32'd0;
      rStep     <= 32'd0;
      rDwell    <= '0;
      rDwellCnt <= '0;
      rPollCnt  <= '0;
      rFirst    <= 1'b0;
      rError    <= 1'b0;
    end else begin
      rState <= nextState;
      if (nextState == sFault) rError <= 1'b1;
      case (rState)
        sIdle: if (iStart) begin
          rCur   <= iFreqInit;
          rFinal <= iFreqFinal;
          rStep  <= iFreqStep;
          rDwell <= iDwell;
          rFirst <= 1'b1;
          rError <= 1'b0;
        end
        sWrFreq: begin
          rFirst   <= 1'b0;
          rPollCnt <= '0;
        end
        sWrEn: rPollCnt <= '0;
        sPoll: begin
          if (nextState == sDwell) rDwellCnt <= rDwell;
          else                     rPollCnt  <= rPollCnt + 1'b1;
        end
        sDwell: begin
          if (rDwellCnt != '0)           rDwellCnt <= rDwellCnt - 1'b1;
          else if (nextState == sWrFreq) rCur      <= nextFreq;
        end
        default: ;
      endcase
    end
  end

  assign oBusy  = (rState != sIdle);
  assign oDone  = (rState == sDone);
  assign oError = rError;
  assign oState = rState;

endmodule
